riscv_ctrl_pipe: RTL

//  Pipelined RV32 control unit with integrated hazard control and optional M-extension sequencing.

---
 rtl/riscv_ctrl_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_ctrl_pipe.sv
// Pipelined RV32 control unit: D-stage decode, E/M/W control registers,
// load-use / branch hazard control and MUL/DIV unit start/stall sequencing.
// ALU codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9,
//   M-ext ops={1,0,funct3}. Imm: I=0 S=1 B=2 J=3 U=4.
// Result mux: ALU=0 MEM=1 PC+4=2 IMM(lui)=4 PC+IMM(auipc)=6 (bit0 set only for loads).
module riscv_ctrl_pipe #(
    parameter int MEXT_EN     = 1,
    parameter int ALU_CTRL_W  = 5,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [6:0]            iop_d,
    input  logic [2:0]            ifunct3_d,
    input  logic [6:0]            ifunct7_d,
    input  logic [4:0]            irs1_d,
    input  logic [4:0]            irs2_d,
    input  logic [4:0]            ird_e,
    input  logic                  ialu_zero,
    input  logic                  ialu_ovfl,
    input  logic                  ialu_carry,
    input  logic                  ialu_neg,
    output logic [ALU_CTRL_W-1:0] oalu_ctrl,
    output logic                  oalu_src,
    output logic                  opc_result_src,
    output logic [2:0]            oimm_src,
    output logic                  opc_src,
    output logic                  oresult_srcb0_e,
    output logic                  odmem_wr_en,
    output logic                  oreg_write_m,
    output logic                  oreg_write_w,
    output logic [2:0]            oresult_src,
    output logic                  ostall_f,
    output logic                  ostall_d,
    output logic                  ostall_e,
    output logic                  oflush_d,
    output logic                  omdu_start,
    input  logic                  imdu_done,
    output logic                  omdu_busy,
    output logic                  omdu_timeout
);
    localparam int CW = $clog2(MDU_TIMEOUT + 1);

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_B = 7'b1100011, OP_I = 7'b0010011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    typedef struct packed {
        logic                  rw;
        logic [2:0]            rs;
        logic                  mw;
        logic                  jmp;
        logic                  br;
        logic [ALU_CTRL_W-1:0] alu;
        logic                  alu_src;
        logic                  pcrs;
        logic [2:0]            f3;
        logic                  mdu;
    } ctrl_e_t;

    typedef struct packed {
        logic       rw;
        logic [2:0] rs;
        logic       mw;
    } ctrl_m_t;

    typedef enum logic {IDLE, RUN} st_t;

    ctrl_e_t        d, e;
    ctrl_m_t        m;
    logic           w_rw;
    logic [2:0]     w_rs;
    logic [2:0]     imm_d;
    logic [1:0]     alu_op;
    st_t            st;
    logic [CW-1:0]  cnt;
    logic           taken, cond, load_use, stall_mdu, tmo_hit, mext_d;

    // Main decode: per-opcode control bundle for the D instruction
    always_comb begin
        d = '0;
        imm_d = 3'd0;
        alu_op = 2'b00;
        d.f3 = ifunct3_d;
        case (iop_d)
            OP_LW:    begin d.rw = 1'b1; d.alu_src = 1'b1; d.rs = 3'd1; end
            OP_SW:    begin d.mw = 1'b1; d.alu_src = 1'b1; imm_d = 3'd1; end
            OP_R:     begin d.rw = 1'b1; alu_op = 2'b10; end
            OP_B:     begin d.br = 1'b1; alu_op = 2'b01; imm_d = 3'd2; end
            OP_I:     begin d.rw = 1'b1; d.alu_src = 1'b1; alu_op = 2'b10; end
            OP_JAL:   begin d.rw = 1'b1; d.jmp = 1'b1; d.rs = 3'd2; imm_d = 3'd3; end
            OP_JALR:  begin d.rw = 1'b1; d.jmp = 1'b1; d.rs = 3'd2; d.alu_src = 1'b1;
                            d.pcrs = 1'b1; end
            OP_LUI:   begin d.rw = 1'b1; d.alu_src = 1'b1; d.rs = 3'd4; imm_d = 3'd4; end
            OP_AUIPC: begin d.rw = 1'b1; d.alu_src = 1'b1; d.rs = 3'd6; imm_d = 3'd4; end
            default:  ;
        endcase
        // ALU decode; M-ext shares the R-type opcode and is told apart by funct7
        mext_d = (MEXT_EN != 0) && (iop_d == OP_R) && (ifunct7_d == 7'b0000001);
        case (alu_op)
            2'b00:   d.alu = ALU_CTRL_W'(ALU_ADD);
            2'b01:   d.alu = ALU_CTRL_W'(ALU_SUB);
            default: begin
                if (mext_d) begin
                    d.alu = ALU_CTRL_W'({2'b10, ifunct3_d});
                    d.mdu = ifunct3_d[2];
                end else begin
                    case (ifunct3_d)
                        3'b000:  d.alu = ALU_CTRL_W'((iop_d[5] & ifunct7_d[5]) ? ALU_SUB : ALU_ADD);
                        3'b001:  d.alu = ALU_CTRL_W'(ALU_SLL);
                        3'b010:  d.alu = ALU_CTRL_W'(ALU_SLT);
                        3'b011:  d.alu = ALU_CTRL_W'(ALU_SLTU);
                        3'b100:  d.alu = ALU_CTRL_W'(ALU_XOR);
                        3'b101:  d.alu = ALU_CTRL_W'(ifunct7_d[5] ? ALU_SRA : ALU_SRL);
                        3'b110:  d.alu = ALU_CTRL_W'(ALU_OR);
                        default: d.alu = ALU_CTRL_W'(ALU_AND);
                    endcase
                end
            end
        endcase
    end

    // Branch resolution in E from funct3 and the SUB flags (carry = no borrow)
    always_comb begin
        case (e.f3)
            3'b000:  cond = ialu_zero;
            3'b001:  cond = ~ialu_zero;
            3'b100:  cond = ialu_neg ^ ialu_ovfl;
            3'b101:  cond = ~(ialu_neg ^ ialu_ovfl);
            3'b110:  cond = ~ialu_carry;
            3'b111:  cond = ialu_carry;
            default: cond = 1'b0;
        endcase
    end

    assign taken     = e.jmp | (e.br & cond);
    assign tmo_hit   = (st == RUN) & ~imdu_done & (cnt == CW'(MDU_TIMEOUT - 1));
    // Timeout releases the stall in its last RUN cycle so E moves on and IDLE cannot re-trigger
    assign stall_mdu = ((st == IDLE) & e.mdu) | ((st == RUN) & ~imdu_done & ~tmo_hit);
    assign load_use  = e.rs[0] & (ird_e != 5'd0) & ((ird_e == irs1_d) | (ird_e == irs2_d))
                     & ~taken & ~stall_mdu;

    // E register: bubble on taken branch or load-use, hold while the MDU stalls
    always_ff @(posedge iclk) begin
        if (irst || taken || load_use) e <= '0;
        else if (!stall_mdu)           e <= d;
    end

    // M/W registers: M takes a bubble for every MDU-stalled cycle
    always_ff @(posedge iclk) begin
        if (irst) begin
            m <= '0;
            w_rw <= 1'b0;
            w_rs <= 3'd0;
        end else begin
            m <= stall_mdu ? '0 : '{rw: e.rw, rs: e.rs, mw: e.mw};
            w_rw <= m.rw;
            w_rs <= m.rs;
        end
    end

    // MDU sequencer: IDLE -> RUN on start, back on done or timeout; timeout flag is sticky
    always_ff @(posedge iclk) begin
        if (irst) begin
            st <= IDLE;
            cnt <= '0;
            omdu_timeout <= 1'b0;
        end else begin
            case (st)
                IDLE: if (e.mdu) begin
                    st <= RUN;
                    cnt <= '0;
                end
                default: begin
                    if (imdu_done) st <= IDLE;
                    else if (tmo_hit) begin
                        st <= IDLE;
                        omdu_timeout <= 1'b1;
                    end else if (cnt != CW'(MDU_TIMEOUT)) cnt <= cnt + CW'(1);
                end
            endcase
        end
    end

    assign oalu_ctrl       = e.alu;
    assign oalu_src        = e.alu_src;
    assign opc_result_src  = e.pcrs;
    assign oimm_src        = imm_d;
    assign opc_src         = taken;
    assign oresult_srcb0_e = e.rs[0];
    assign odmem_wr_en     = m.mw;
    assign oreg_write_m    = m.rw;
    assign oreg_write_w    = w_rw;
    assign oresult_src     = w_rs;
    assign ostall_f        = load_use | stall_mdu;
    assign ostall_d        = load_use | stall_mdu;
    assign ostall_e        = stall_mdu;
    assign oflush_d        = taken;
    assign omdu_start      = (st == IDLE) & e.mdu;
    assign omdu_busy       = (st == RUN);
endmodule
